// File: rtl/spi_slave_param.sv
// spi_slave_param: parametrised SPI slave (width, mode, bit order, MISO idle).
// SCLK is the only clock; the sample and shift edges are selected by MODE.
module spi_slave_param #(
  parameter int WIDTH     = 8,
  parameter int MODE      = 0,
  parameter bit LSB_FIRST = 1'b1,
  parameter bit MISO_HIZ  = 1'b1
) (
  input  logic             SCLK,
  input  logic             reset,
  input  logic             CS,
  input  logic             MOSI,
  output logic             MISO,
  input  logic [WIDTH-1:0] slaveDataToSend,
  output logic [WIDTH-1:0] slaveDataReceived,
  output logic             dataValid,
  output logic             dataLoaded,
  output logic [7:0]       wordCount,
  output logic             frameAborted
);

  localparam int              CW    = $clog2(WIDTH);
  localparam logic [1:0]      M     = 2'(MODE);
  localparam logic            CPOL  = M[1];
  localparam logic            CPHA  = M[0];
  localparam logic [CW-1:0]   LAST  = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   FIRST = LSB_FIRST ? '0 : LAST;

  logic             w_sclk;
  logic [WIDTH-1:0] r_rx;
  logic [WIDTH-1:0] r_tx;
  logic [WIDTH-1:0] r_rxd;
  logic [CW-1:0]    r_cnt;
  logic             r_dv;
  logic             r_dl;
  logic             r_fa;
  logic             r_miso;
  logic [7:0]       r_wc;
  logic [WIDTH-1:0] w_rx_next;
  logic             w_last;
  logic             w_bit;
  logic             w_drive;

  // posedge of w_sclk is always the sample edge, negedge the shift edge
  assign w_sclk = SCLK ^ (CPOL ^ CPHA);

  function automatic logic [CW-1:0] f_idx(input logic [CW-1:0] n);
    return LSB_FIRST ? n : LAST - n;
  endfunction

  always_comb begin
    w_rx_next = r_rx;
    w_rx_next[f_idx(r_cnt)] = MOSI;
  end

  assign w_last = (r_cnt == LAST);

  always_ff @(posedge w_sclk or negedge reset) begin
    if (!reset) begin
      r_rx  <= '0;
      r_rxd <= '0;
      r_cnt <= '0;
      r_dv  <= 1'b0;
      r_wc  <= '0;
      r_fa  <= 1'b0;
    end else if (CS) begin
      r_rx  <= '0;
      r_cnt <= '0;
      r_wc  <= '0;
      r_dv  <= 1'b0;
      if (r_cnt != '0)
        r_fa <= 1'b1;
    end else begin
      r_dv <= w_last;
      if (w_last) begin
        r_rxd <= w_rx_next;
        r_rx  <= '0;
        r_cnt <= '0;
        r_wc  <= r_wc + 8'd1;
        r_fa  <= 1'b0;
      end else begin
        r_rx  <= w_rx_next;
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  generate
    if (CPHA == 1'b0) begin : g_cpha0
      logic r_mid;

      always_ff @(posedge w_sclk or negedge reset) begin
        if (!reset) begin
          r_tx <= '0;
          r_dl <= 1'b0;
        end else begin
          r_dl <= !CS && (r_cnt == '0);
          if (!CS && (r_cnt == '0))
            r_tx <= slaveDataToSend;
        end
      end

      // r_mid: a shifted bit is on r_miso; otherwise show the word's first bit
      always_ff @(negedge w_sclk or negedge reset) begin
        if (!reset) begin
          r_miso <= 1'b0;
          r_mid  <= 1'b0;
        end else begin
          r_mid <= !CS && (r_cnt != '0);
          if (!CS && (r_cnt != '0))
            r_miso <= r_tx[f_idx(r_cnt)];
        end
      end

      assign w_bit = r_mid ? r_miso :
                     (r_cnt == '0) ? slaveDataToSend[FIRST] :
                     r_tx[FIRST];
    end else begin : g_cpha1
      always_ff @(negedge w_sclk or negedge reset) begin
        if (!reset) begin
          r_tx   <= '0;
          r_dl   <= 1'b0;
          r_miso <= 1'b0;
        end else if (!CS && (r_cnt == '0)) begin
          r_tx   <= slaveDataToSend;
          r_dl   <= 1'b1;
          r_miso <= slaveDataToSend[FIRST];
        end else begin
          r_dl <= 1'b0;
          if (!CS)
            r_miso <= r_tx[f_idx(r_cnt)];
        end
      end

      assign w_bit = r_miso;
    end
  endgenerate

  assign w_drive = reset && !CS;
  assign MISO    = w_drive ? w_bit : (MISO_HIZ ? 1'bz : 1'b0);

  assign slaveDataReceived = r_rxd;
  assign dataValid         = r_dv;
  assign dataLoaded        = r_dl;
  assign wordCount         = r_wc;
  assign frameAborted      = r_fa;

endmodule
